// File: rtl/matrix_pkg.sv
// Shared frame geometry for the LED matrix path: window size, frame width,
// the column/row-to-frame-bit mapping and the scroll-length clamp floor.
package matrix_pkg;

    localparam int MATRIX_DIM = 8;
    localparam int FRAME_W    = MATRIX_DIM * MATRIX_DIM;
    localparam int LEN_MIN    = MATRIX_DIM;

    // Frame bit carrying row `row` of window column `col`.
    function automatic int frame_bit(input int col, input int row);
        return col * MATRIX_DIM + row;
    endfunction

endpackage

// File: rtl/matrix_scroll_buffer_column_store.sv
// Column bitmap store: DEPTH x 8 register array with one synchronous write
// port and one combinational read port per window column.
module column_store
    import matrix_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_wr_en,
    input  logic [ADDR_W-1:0]                    i_wr_addr,
    input  logic [7:0]                           i_wr_data,
    input  logic [MATRIX_DIM-1:0][ADDR_W-1:0]    i_rd_addr,
    output logic [MATRIX_DIM-1:0][7:0]           o_rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar c = 0; c < MATRIX_DIM; c++) begin : g_rd
        assign o_rd_data[c] = r_mem[i_rd_addr[c]];
    end

endmodule

// File: rtl/matrix_scroll_buffer.sv
// Scrolling 8-column window over a column bitmap, presented as a registered
// 64-bit frame for the LED matrix controller.
module matrix_scroll_buffer
    import matrix_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int DEF_LEN = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_scroll_tick,
    input  logic                i_run,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [7:0]          i_wr_data,
    input  logic                i_len_wr,
    input  logic [ADDR_W:0]     i_len_data,
    output logic [FRAME_W-1:0]  o_matrix_out,
    output logic                o_wrap
);

    localparam logic [ADDR_W:0] LEN_LO  = (ADDR_W+1)'(LEN_MIN);
    localparam logic [ADDR_W:0] LEN_HI  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_DEF = (ADDR_W+1)'(DEF_LEN);

    logic [ADDR_W-1:0]                  r_start;
    logic [ADDR_W:0]                    r_len;
    logic                               r_wrap;
    logic [FRAME_W-1:0]                 r_matrix_out;

    logic [ADDR_W:0]                    w_start_inc;
    logic                               w_adv;
    logic                               w_hit;
    logic [ADDR_W:0]                    w_len_clamped;
    logic [MATRIX_DIM-1:0][ADDR_W-1:0]  w_rd_addr;
    logic [MATRIX_DIM-1:0][7:0]         w_rd_data;
    logic [FRAME_W-1:0]                 w_frame;

    assign w_start_inc = {1'b0, r_start} + 1'b1;
    assign w_adv       = i_scroll_tick & i_run & ~i_len_wr;
    assign w_hit       = (w_start_inc == r_len);

    always_comb begin
        w_len_clamped = i_len_data;
        if (i_len_data < LEN_LO) begin
            w_len_clamped = LEN_LO;
        end else if (i_len_data > LEN_HI) begin
            w_len_clamped = LEN_HI;
        end
    end

    // start < len and c < 8 <= len, so one conditional subtract is a full modulo.
    for (genvar c = 0; c < MATRIX_DIM; c++) begin : g_win
        logic [ADDR_W:0] w_sum;
        logic [ADDR_W:0] w_idx;
        assign w_sum = {1'b0, r_start} + (ADDR_W+1)'(c);
        assign w_idx = (w_sum >= r_len) ? (w_sum - r_len) : w_sum;
        assign w_rd_addr[c] = w_idx[ADDR_W-1:0];
    end

    column_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_store (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    for (genvar c = 0; c < MATRIX_DIM; c++) begin : g_col
        for (genvar r = 0; r < MATRIX_DIM; r++) begin : g_row
            assign w_frame[frame_bit(c, r)] = w_rd_data[c][r];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start      <= '0;
            r_len        <= LEN_DEF;
            r_wrap       <= 1'b0;
            r_matrix_out <= '0;
        end else begin
            r_matrix_out <= w_frame;
            r_wrap       <= 1'b0;
            if (i_len_wr) begin
                r_len   <= w_len_clamped;
                r_start <= '0;
            end else if (w_adv) begin
                r_start <= w_hit ? '0 : w_start_inc[ADDR_W-1:0];
                r_wrap  <= w_hit;
            end
        end
    end

    assign o_matrix_out = r_matrix_out;
    assign o_wrap       = r_wrap;

endmodule

// File: doc/matrix_scroll_buffer.md
Name: matrix_scroll_buffer

Overview:
Upstream feeder of the LED matrix controller. Produces the 64-bit frame it scans onto rows and columns.
Holds a column bitmap of up to DEPTH 8-bit columns, written by game/host logic. Presents an 8-column window of that bitmap as a 64-bit frame, and advances the window one column per scroll tick (normally the 100 ms timeout), wrapping at a programmable length.
Replaces the mock matrix stream used in simulation.

Parameters:
DEPTH, 32, number of column slots in the bitmap store (power of two, minimum 8)
ADDR_W, 5, column address width, equal to clog2(DEPTH)
DEF_LEN, 8, scroll length loaded at reset (8 ≤ DEF_LEN ≤ DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
scroll_tick  in  1  single-cycle pulse; advances the window by one column when run=1
run  in  1  1 = scrolling enabled; 0 = window frozen
wr_en  in  1  column write strobe
wr_addr  in  ADDR_W  column slot to write
wr_data  in  8  column bits; bit r = row r
len_wr  in  1  scroll-length load strobe
len_data  in  ADDR_W+1  requested scroll length in columns
matrix_out  out  64  frame to controller; matrix_out[8*c+r] = row r of window column c
wrap  out  1  one-cycle pulse when the window start returns to 0 through scrolling

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State:
  - mem[0..DEPTH-1], 8 bits each
  - start, ADDR_W bits
  - len, ADDR_W+1 bits
- Reset (rst=1 at a clk edge):
  - every mem slot = 0
  - start = 0
  - len = DEF_LEN
  - matrix_out = 64'h0
  - wrap = 0
  - rst overrides every other input in that cycle.
- Column write: wr_en=1 with wr_addr<DEPTH sets mem[wr_addr] = wr_data at the edge. Because ADDR_W = clog2(DEPTH), every address is in range.
- Length load: len_wr=1 sets len = clamp(len_data, 8, DEPTH) and start = 0. A value of 0–7 becomes 8; a value above DEPTH becomes DEPTH.
- Scroll: scroll_tick=1 with run=1 and len_wr=0:
  - start = (start+1 == len) ? 0 : start+1
  - when start wraps to 0, wrap = 1 for exactly the next cycle
  - otherwise wrap = 0
- Frozen: run=0 ignores ticks; start holds; wrap stays 0.
- Window: column c (0..7) = mem[(start + c) mod len]. The modulo uses a single conditional subtract, which is valid because start < len and c < 8 ≤ len.
- Output register:
  - matrix_out is registered and recomputed every cycle from the post-edge state.
  - Latency is 1 cycle: a write, tick or length load at edge N shows in matrix_out after edge N+1.
  - matrix_out never shows a partially updated frame.
- Simultaneous events:
  - wr_en and scroll_tick in the same cycle: both apply; the frame after the next edge reflects the new data at the new start.
  - len_wr and scroll_tick in the same cycle: len_wr wins; start = 0 and no wrap pulse.
  - len_wr and wr_en in the same cycle: both apply.
  - Writing a slot at or beyond len is legal; that slot is stored but not displayed until len grows.
- Length shrink: len_wr always forces start = 0, so start < len always holds.
- Reset mid-scroll: the next frame after reset is all zeros, and the bitmap contents are lost.

Decomposition:
- Shared package (matrix_pkg):
  - MATRIX_DIM = 8
  - FRAME_W = 64
  - the column/row-to-frame-bit mapping function, also used by the controller and by bench checkers
  - the clamp bounds
- One sub-module, column_store: the DEPTH x 8 register array.
  - one synchronous write port
  - eight combinational read ports addressed by the window index logic
- Pointer, length and window logic stay in matrix_scroll_buffer.

Test Plan:
1. Reset, then idle 3 cycles: matrix_out = 64'h0, wrap = 0, len = 8. A scroll_tick with run=1 eight times returns start to 0, and wrap pulses once, on the 8th tick.
2. Write mem[c] = 8'h01<<c for c = 0..7, run=0: after the last write plus 1 cycle, matrix_out = 64'h8040201008040201. Ticks cause no change.
3. From scenario 2, run=1 and one tick: matrix_out = 64'h0180402010080402, i.e. column 0 shows mem[1] and column 7 shows mem[0].
4. len_data=12 with mem[8..11] = 8'hFF, then tick 4 times: matrix_out = 64'hFFFFFFFF80402010. After 12 ticks total, start = 0 and wrap pulses exactly once.
5. len_data = 3 gives len 8; len_data = 40 with DEPTH 32 gives len 32. len_wr and scroll_tick in the same cycle give start = 0 and wrap = 0.
6. rst asserted mid-scroll with start = 5: the next cycle shows matrix_out = 0, start = 0, len = DEF_LEN, and mem reads back 0 on the following frames.
